// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse transmitter: FSM states, element
// encoding, element limit, default unit timings and the unit-counter width.
package morse_pkg;

  localparam int MAX_ELEMS = 6;
  localparam int CNT_W     = 8;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  localparam int DEF_DOT_UNITS      = 1;
  localparam int DEF_DASH_UNITS     = 3;
  localparam int DEF_ELEM_GAP_UNITS = 1;
  localparam int DEF_CHAR_GAP_UNITS = 3;
  localparam int DEF_WORD_GAP_UNITS = 7;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    ELEM_GAP,
    CHAR_GAP,
    WORD_GAP
  } state_t;

  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    return (len > 3'(MAX_ELEMS)) ? 3'(MAX_ELEMS) : len;
  endfunction

endpackage

// File: rtl/morse_tx_unit_cnt.sv
// Loadable down-counter of unit ticks; expire flags the tick that ends a phase.
// A load takes priority, so a tick coinciding with a load is not counted.
module morse_tx_unit_cnt
  import morse_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  assign expire = tick && (count == CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/morse_tx.sv
// Morse character transmitter: keys dots/dashes with element, character and
// word gaps. Optional word-space timing is enabled by MORSE_TX_WORD_GAP_EN.
module morse_tx
  import morse_pkg::*;
#(
  parameter int DOT_UNITS      = DEF_DOT_UNITS,
  parameter int DASH_UNITS     = DEF_DASH_UNITS,
  parameter int ELEM_GAP_UNITS = DEF_ELEM_GAP_UNITS,
  parameter int CHAR_GAP_UNITS = DEF_CHAR_GAP_UNITS,
  parameter int WORD_GAP_UNITS = DEF_WORD_GAP_UNITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_len,
  input  logic [5:0] in_bits,
  output logic       key,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] DOT_CNT  = CNT_W'(DOT_UNITS);
  localparam logic [CNT_W-1:0] DASH_CNT = CNT_W'(DASH_UNITS);
  localparam logic [CNT_W-1:0] EGAP_CNT = CNT_W'(ELEM_GAP_UNITS);
  localparam logic [CNT_W-1:0] CGAP_CNT = CNT_W'(CHAR_GAP_UNITS);
`ifdef MORSE_TX_WORD_GAP_EN
  localparam logic [CNT_W-1:0] WGAP_CNT = CNT_W'(WORD_GAP_UNITS - CHAR_GAP_UNITS);
`endif

  state_t           state;
  logic [2:0]       remain;
  logic [5:0]       shreg;
  logic [2:0]       len_c;
  logic [2:0]       shamt;
  logic [5:0]       aligned;
  logic             accept;
  logic             expire;
  logic             load;
  logic [CNT_W-1:0] load_val;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign len_c    = clamp_len(in_len);
  assign shamt    = 3'(MAX_ELEMS) - len_c;
  // Left-align so the first element to send always sits in bit 5
  assign aligned  = in_bits << shamt;

  always_comb begin
    load     = 1'b0;
    load_val = '0;
    case (state)
      IDLE: begin
        if (accept && (len_c != 3'd0)) begin
          load     = 1'b1;
          load_val = (aligned[5] == DASH) ? DASH_CNT : DOT_CNT;
        end
`ifdef MORSE_TX_WORD_GAP_EN
        else if (accept) begin
          load     = 1'b1;
          load_val = WGAP_CNT;
        end
`endif
      end
      MARK: begin
        if (expire) begin
          load     = 1'b1;
          load_val = (remain != 3'd0) ? EGAP_CNT : CGAP_CNT;
        end
      end
      ELEM_GAP: begin
        if (expire) begin
          load     = 1'b1;
          load_val = (shreg[5] == DASH) ? DASH_CNT : DOT_CNT;
        end
      end
      default: ;
    endcase
  end

  morse_tx_unit_cnt u_cnt (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (load),
    .load_val (load_val),
    .expire   (expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      key    <= 1'b0;
      done   <= 1'b0;
      shreg  <= '0;
      remain <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (len_c != 3'd0) begin
              state  <= MARK;
              key    <= 1'b1;
              shreg  <= aligned << 1;
              remain <= len_c - 3'd1;
            end else begin
`ifdef MORSE_TX_WORD_GAP_EN
              state <= WORD_GAP;
`else
              done  <= 1'b1;
`endif
            end
          end
        end
        MARK: begin
          if (expire) begin
            key   <= 1'b0;
            state <= (remain != 3'd0) ? ELEM_GAP : CHAR_GAP;
          end
        end
        ELEM_GAP: begin
          if (expire) begin
            state  <= MARK;
            key    <= 1'b1;
            shreg  <= shreg << 1;
            remain <= remain - 3'd1;
          end
        end
        CHAR_GAP, WORD_GAP: begin
          if (expire) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          key   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_tx.sv
// Directed bench for morse_tx: timing of characters, word space, backpressure,
// reset mid-dash and clamping of over-long characters.
module tb_morse_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_len = 3'd0;
  logic [5:0] in_bits = 6'd0;
  logic       key;
  logic       busy;
  logic       done;

  int n_asrt = 0;
  int n_fail = 0;

  morse_tx dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_len   (in_len),
    .in_bits  (in_bits),
    .key      (key),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One unit: three quiet cycles then a tick cycle; returns just after the tick edge
  task automatic unit();
    tick = 1'b0;
    repeat (3) step();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic send(input logic [2:0] len, input logic [5:0] bits);
    in_valid = 1'b1;
    in_len   = len;
    in_bits  = bits;
    step();
    in_valid = 1'b0;
  endtask

  // Key level per unit is pat[u]; done must follow the last unit
  task automatic play(input string tag, input int n, input logic [15:0] pat);
    chk({tag, " key u0"}, key, pat[0]);
    chk({tag, " busy"}, busy, 1'b1);
    for (int u = 1; u < n; u++) begin
      unit();
      chk({tag, " key"}, key, pat[u]);
      chk({tag, " no done"}, done, 1'b0);
      chk({tag, " ready low"}, in_ready, 1'b0);
    end
    unit();
    chk({tag, " done"}, done, 1'b1);
    chk({tag, " key end"}, key, 1'b0);
    chk({tag, " idle"}, busy, 1'b0);
    step();
    chk({tag, " done 1cyc"}, done, 1'b0);
  endtask

  initial begin
    int cnt;

    // Reset state
    step();
    chk("rst key", key, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    rst = 1'b1;
    step();
    chk("ready after rst", in_ready, 1'b1);

    // 'E' with a tick in the acceptance cycle, which must be ignored
    tick = 1'b1;
    send(3'd1, 6'b000000);
    tick = 1'b0;
    chk("E ready low", in_ready, 1'b0);
    play("E", 4, 16'b0001);

    // 'A' = dot dash
    send(3'd2, 6'b000001);
    play("A", 8, 16'b0000_0000_0001_1101);

    // Word space
`ifdef MORSE_TX_WORD_GAP_EN
    send(3'd0, 6'b000000);
    play("WSP", 4, 16'b0000);
`else
    send(3'd0, 6'b000000);
    chk("WSP done", done, 1'b1);
    chk("WSP busy", busy, 1'b0);
    chk("WSP ready", in_ready, 1'b1);
    step();
    chk("WSP done 1cyc", done, 1'b0);
`endif

    // Backpressure: 'T' held valid while 'E' is sending
    in_valid = 1'b1;
    in_len   = 3'd1;
    in_bits  = 6'b000000;
    step();
    in_bits  = 6'b000001;
    play("E bp", 4, 16'b0001);
    in_valid = 1'b0;
    play("T", 6, 16'b000111);

    // Reset during the second tick of a dash
    send(3'd1, 6'b000001);
    unit();
    chk("dash key t1", key, 1'b1);
    repeat (3) step();
    tick = 1'b1;
    rst  = 1'b0;
    #1;
    chk("rst key now", key, 1'b0);
    chk("rst busy now", busy, 1'b0);
    chk("rst done now", done, 1'b0);
    #2;
    tick = 1'b0;
    rst  = 1'b1;
    step();
    chk("ready after rst2", in_ready, 1'b1);
    send(3'd1, 6'b000000);
    play("E post rst", 4, 16'b0001);

    // Continuous tick, in_len=7 clamped to 6 dashes
    tick = 1'b1;
    send(3'd7, 6'b111111);
    cnt = 0;
    while (!done && cnt < 100) begin
      step();
      cnt++;
    end
    tick = 1'b0;
    chk("clamp cycles", cnt, 26);
    chk("clamp key", key, 1'b0);
    step();
    chk("clamp done 1cyc", done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
